// File: rtl/hsci_xfer_arb_pkg.sv
// Shared widths, FSM encoding and descriptor type for the HSCI transfer arbiter.
package hsci_xfer_arb_pkg;

   localparam int CMD_W  = 2;
   localparam int XFER_W = 16;
   localparam int BYTE_W = 3;
   localparam int ASZ_W  = 3;
   localparam int BRAM_W = 15;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      XA_IDLE       = 3'd0,
      XA_LOAD       = 3'd1,
      XA_RUN        = 3'd2,
      XA_WAIT_START = 3'd3,
      XA_WAIT_DONE  = 3'd4,
      XA_RESP       = 3'd5
   } xfer_arb_state_t;

   typedef struct packed {
      logic [CMD_W-1:0]  cmd_sel;
      logic [XFER_W-1:0] xfer_num;
      logic [BYTE_W-1:0] byte_num;
      logic [ASZ_W-1:0]  addr_size;
      logic [BRAM_W-1:0] bram_addr;
   } xfer_desc_t;

   // Timeout counters hold at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/hsci_xfer_arbiter_if.sv
// Requester-side and core-side signal bundle of the HSCI transfer arbiter.
// The slave modport is the arbiter's view; master is the requesters/core view.
interface hsci_xfer_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import hsci_xfer_arb_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [CMD_W*NUM_REQ-1:0]  req_cmd_sel;
   logic [XFER_W*NUM_REQ-1:0] req_xfer_num;
   logic [BYTE_W*NUM_REQ-1:0] req_byte_num;
   logic [ASZ_W*NUM_REQ-1:0]  req_addr_size;
   logic [BRAM_W*NUM_REQ-1:0] req_bram_addr;
   logic [NUM_REQ-1:0]        ack;
   logic [NUM_REQ-1:0]        err;
   logic [NUM_REQ-1:0]        grant;
   logic                      busy;

   logic [CMD_W-1:0]          hsci_cmd_sel;
   logic [XFER_W-1:0]         hsci_xfer_num;
   logic [BYTE_W-1:0]         hsci_byte_num;
   logic [ASZ_W-1:0]          hsci_addr_size;
   logic [BRAM_W-1:0]         hsci_bram_addr;
   logic                      hsci_master_run;
   logic                      master_running;
   logic                      master_done;
   logic                      core_err;

   modport slave (
      input  req, req_cmd_sel, req_xfer_num, req_byte_num, req_addr_size, req_bram_addr,
      input  master_running, master_done, core_err,
      output ack, err, grant, busy,
      output hsci_cmd_sel, hsci_xfer_num, hsci_byte_num, hsci_addr_size, hsci_bram_addr,
      output hsci_master_run
   );

   modport master (
      output req, req_cmd_sel, req_xfer_num, req_byte_num, req_addr_size, req_bram_addr,
      output master_running, master_done, core_err,
      input  ack, err, grant, busy,
      input  hsci_cmd_sel, hsci_xfer_num, hsci_byte_num, hsci_addr_size, hsci_bram_addr,
      input  hsci_master_run
   );

endinterface

// File: rtl/hsci_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo NUM_REQ.
module hsci_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W:0] cand;

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!any && req[cand[IDX_W-1:0]]) begin
            any = 1'b1;
            idx = cand[IDX_W-1:0];
         end
      end
      onehot = any ? (NUM_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/hsci_xfer_arbiter.sv
// Shares one HSCI master core between NUM_REQ requesters with round-robin arbitration.
// Define HSCI_XFER_TIMEOUT_EN to add the WAIT_DONE timeout and the sticky tmo_flag output.
module hsci_xfer_arbiter
   import hsci_xfer_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int START_TMO = 16
`ifdef HSCI_XFER_TIMEOUT_EN
   ,
   parameter int XFER_TMO  = 65535
`endif
) (
   input  logic                hsci_pclk,
   input  logic                hsci_rst,
   hsci_xfer_arbiter_if.slave  bus
`ifdef HSCI_XFER_TIMEOUT_EN
   ,
   output logic                tmo_flag
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [2:0] ST_IDLE       = XA_IDLE;
   localparam logic [2:0] ST_LOAD       = XA_LOAD;
   localparam logic [2:0] ST_RUN        = XA_RUN;
   localparam logic [2:0] ST_WAIT_START = XA_WAIT_START;
   localparam logic [2:0] ST_WAIT_DONE  = XA_WAIT_DONE;
   localparam logic [2:0] ST_RESP       = XA_RESP;

   localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TMO - 1);
`ifdef HSCI_XFER_TIMEOUT_EN
   localparam logic [CNT_W-1:0] XFER_LIM  = CNT_W'(XFER_TMO - 1);
`endif

   logic [2:0]         state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] ack_q;
   logic [NUM_REQ-1:0] err_q;
   logic               run_q;
   logic [CNT_W-1:0]   cnt;
   xfer_desc_t         desc_q;

   logic               pick_any;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   xfer_desc_t         desc_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_desc
      assign desc_arr[i] = '{
         cmd_sel:   bus.req_cmd_sel[i*CMD_W +: CMD_W],
         xfer_num:  bus.req_xfer_num[i*XFER_W +: XFER_W],
         byte_num:  bus.req_byte_num[i*BYTE_W +: BYTE_W],
         addr_size: bus.req_addr_size[i*ASZ_W +: ASZ_W],
         bram_addr: bus.req_bram_addr[i*BRAM_W +: BRAM_W]
      };
   end

   hsci_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (bus.req),
      .ptr     (rr_ptr),
      .any     (pick_any),
      .onehot  (pick_oh),
      .idx     (pick_idx)
   );

   // The run pulse is registered on leaving RUN, so it lands two cycles after grant.
   always_ff @(posedge hsci_pclk) begin
      if (hsci_rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         grant_q   <= '0;
         ack_q     <= '0;
         err_q     <= '0;
         run_q     <= 1'b0;
         cnt       <= '0;
         desc_q    <= '0;
`ifdef HSCI_XFER_TIMEOUT_EN
         tmo_flag  <= 1'b0;
`endif
      end else begin
         run_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_q   <= pick_oh;
                  grant_idx <= pick_idx;
                  desc_q    <= desc_arr[pick_idx];
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: state <= ST_RUN;
            ST_RUN: begin
               run_q <= 1'b1;
               cnt   <= '0;
               state <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (bus.master_running) begin
                  cnt   <= '0;
                  state <= ST_WAIT_DONE;
               end else if (cnt >= START_LIM) begin
                  ack_q <= grant_q;
                  err_q <= grant_q;
                  state <= ST_RESP;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            ST_WAIT_DONE: begin
               if (bus.master_done && !bus.master_running) begin
                  ack_q <= grant_q;
                  err_q <= bus.core_err ? grant_q : '0;
                  state <= ST_RESP;
               end
`ifdef HSCI_XFER_TIMEOUT_EN
               else if (cnt >= XFER_LIM) begin
                  ack_q    <= grant_q;
                  err_q    <= grant_q;
                  tmo_flag <= 1'b1;
                  state    <= ST_RESP;
               end else begin
                  cnt <= sat_inc(cnt);
               end
`endif
            end
            ST_RESP: begin
               ack_q   <= '0;
               err_q   <= '0;
               grant_q <= '0;
               rr_ptr  <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ack             = ack_q;
   assign bus.err             = err_q;
   assign bus.grant           = grant_q;
   assign bus.busy            = (state != ST_IDLE);
   assign bus.hsci_master_run = run_q;
   assign bus.hsci_cmd_sel    = desc_q.cmd_sel;
   assign bus.hsci_xfer_num   = desc_q.xfer_num;
   assign bus.hsci_byte_num   = desc_q.byte_num;
   assign bus.hsci_addr_size  = desc_q.addr_size;
   assign bus.hsci_bram_addr  = desc_q.bram_addr;

endmodule

// File: tb/tb_hsci_xfer_arbiter.sv
// Self-checking bench for hsci_xfer_arbiter with three requesters and a small core model.
// Define HSCI_XFER_TIMEOUT_EN to also exercise the transfer timeout and tmo_flag.
module tb_hsci_xfer_arbiter;
   import hsci_xfer_arb_pkg::*;

   localparam int NR        = 3;
   localparam int START_TMO = 16;
`ifdef HSCI_XFER_TIMEOUT_EN
   localparam int XFER_TMO  = 100;
   logic tmo_flag;
`endif

   typedef struct {
      int          idx;
      logic        err;
      logic [15:0] xfer;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   logic [15:0] d_xfer [NR];
   logic [14:0] d_bram [NR];

   int run_len     = 3;
   bit never_run   = 1'b0;
   bit stuck_run   = 1'b0;
   bit err_on_done = 1'b0;
   int cm_left     = 0;
   bit cm_active   = 1'b0;

   hsci_xfer_arbiter_if #(.NUM_REQ(NR)) bus ();

   hsci_xfer_arbiter #(
      .NUM_REQ   (NR),
      .START_TMO (START_TMO)
`ifdef HSCI_XFER_TIMEOUT_EN
      ,
      .XFER_TMO  (XFER_TMO)
`endif
   ) dut (
      .hsci_pclk (clk),
      .hsci_rst  (rst),
      .bus       (bus)
`ifdef HSCI_XFER_TIMEOUT_EN
      ,
      .tmo_flag  (tmo_flag)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: running rises on the run pulse, holds run_len cycles, then done (level).
   always @(negedge clk) begin
      if (rst) begin
         bus.master_running = 1'b0;
         bus.master_done    = 1'b0;
         bus.core_err       = 1'b0;
         cm_active          = 1'b0;
      end else if (bus.hsci_master_run) begin
         bus.master_done = 1'b0;
         bus.core_err    = 1'b0;
         if (!never_run) begin
            bus.master_running = 1'b1;
            cm_active          = 1'b1;
            cm_left            = run_len;
         end
      end else if (cm_active && !stuck_run) begin
         if (cm_left > 1) begin
            cm_left--;
         end else begin
            bus.master_running = 1'b0;
            bus.master_done    = 1'b1;
            bus.core_err       = err_on_done;
            cm_active          = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic set_desc(input int i, input logic [1:0] cs, input logic [15:0] xn,
                           input logic [2:0] bn, input logic [2:0] as, input logic [14:0] ba);
      bus.req_cmd_sel[i*2 +: 2]    = cs;
      bus.req_xfer_num[i*16 +: 16] = xn;
      bus.req_byte_num[i*3 +: 3]   = bn;
      bus.req_addr_size[i*3 +: 3]  = as;
      bus.req_bram_addr[i*15 +: 15] = ba;
      d_xfer[i] = xn;
      d_bram[i] = ba;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_ack(input int limit, output bit got, output int at);
      got = 1'b0;
      at  = -1;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (bus.ack != '0) begin
            got = 1'b1;
            at  = cyc;
         end
      end
   endtask

   task automatic test_reset();
      bus.req = '0;
      for (int i = 0; i < NR; i++) set_desc(i, 2'd0, 16'd0, 3'd0, 3'd0, 15'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      n_cmp++;
      if (bus.grant !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_grant: got %b expected 000", bus.grant); end
      n_cmp++;
      if ({bus.ack, bus.err} !== 6'b0) begin n_bad++; $display("[TB] FAIL reset_ack_err: got %b expected 000000", {bus.ack, bus.err}); end
      n_cmp++;
      if (bus.hsci_master_run !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_run: got %b expected 0", bus.hsci_master_run); end
      n_cmp++;
      if ({bus.hsci_cmd_sel, bus.hsci_xfer_num, bus.hsci_byte_num, bus.hsci_addr_size, bus.hsci_bram_addr} !== 39'd0) begin
         n_bad++;
         $display("[TB] FAIL reset_desc: got %h expected 0",
                  {bus.hsci_cmd_sel, bus.hsci_xfer_num, bus.hsci_byte_num, bus.hsci_addr_size, bus.hsci_bram_addr});
      end
`ifdef HSCI_XFER_TIMEOUT_EN
      n_cmp++;
      if (tmo_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tmo_flag: got %b expected 0", tmo_flag); end
`endif
   endtask

   task automatic test_contention();
      bit got;
      int at;
      exp_t e;
      logic [NR-1:0] oh;
      run_len = 3;
      for (int i = 0; i < NR; i++)
         set_desc(i, 2'(i), 16'h0100 + 16'(i), 3'(i + 1), 3'(i + 2), 15'h0200 + 15'(i));
      sb.push_back(exp_t'{idx: 0, err: 1'b0, xfer: 16'h0100});
      sb.push_back(exp_t'{idx: 1, err: 1'b0, xfer: 16'h0101});
      sb.push_back(exp_t'{idx: 2, err: 1'b0, xfer: 16'h0102});
      sb.push_back(exp_t'{idx: 0, err: 1'b0, xfer: 16'h0100});
      @(negedge clk);
      bus.req = 3'b111;
      for (int n = 0; n < 4; n++) begin
         wait_ack(200, got, at);
         e = sb.pop_front();
         oh = '0;
         oh[e.idx] = 1'b1;
         n_cmp++;
         if (!got) begin
            n_bad++;
            $display("[TB] FAIL contention_ack_%0d: no ack seen, expected ack to requester %0d", n, e.idx);
         end else begin
            if (bus.ack !== oh) begin n_bad++; $display("[TB] FAIL contention_ack_%0d: got %b expected %b", n, bus.ack, oh); end
            n_cmp++;
            if (bus.grant !== oh) begin n_bad++; $display("[TB] FAIL contention_grant_%0d: got %b expected %b", n, bus.grant, oh); end
            n_cmp++;
            if (bus.err !== 3'b000) begin n_bad++; $display("[TB] FAIL contention_err_%0d: got %b expected 000", n, bus.err); end
            n_cmp++;
            if (bus.hsci_xfer_num !== e.xfer) begin
               n_bad++;
               $display("[TB] FAIL contention_xfer_%0d: got %h expected %h", n, bus.hsci_xfer_num, e.xfer);
            end
         end
      end
      bus.req = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      int g_at, r_at, a_at, runs, bad_hold;
      logic [NR-1:0] g_val, a_val, e_val;
      logic [14:0] bram_val;
      exp_t e;
      run_len = 20;
      set_desc(0, 2'd1, 16'd4, 3'd2, 3'd3, 15'h0010);
      sb.push_back(exp_t'{idx: 0, err: 1'b0, xfer: 16'd4});
      g_at = -1; r_at = -1; a_at = -1; runs = 0; bad_hold = 0;
      g_val = '0; a_val = '0; e_val = '0; bram_val = '0;
      @(negedge clk);
      bus.req = 3'b001;
      for (int i = 0; i < 200 && a_at < 0; i++) begin
         @(negedge clk);
         if (g_at < 0 && bus.grant != '0) begin g_at = cyc; g_val = bus.grant; end
         if (bus.hsci_master_run) begin runs++; if (r_at < 0) r_at = cyc; end
         if (bus.busy && bus.hsci_xfer_num !== 16'd4) bad_hold++;
         if (bus.ack != '0) begin
            a_at = cyc; a_val = bus.ack; e_val = bus.err; bram_val = bus.hsci_bram_addr;
            bus.req = '0;
         end
      end
      e = sb.pop_front();
      n_cmp++;
      if (g_val !== 3'b001) begin n_bad++; $display("[TB] FAIL single_grant: got %b expected 001", g_val); end
      n_cmp++;
      if (r_at - g_at !== 2) begin n_bad++; $display("[TB] FAIL single_grant_to_run: got %0d expected 2", r_at - g_at); end
      n_cmp++;
      if (runs !== 1) begin n_bad++; $display("[TB] FAIL single_run_width: got %0d expected 1", runs); end
      n_cmp++;
      if (a_at - r_at !== 21) begin n_bad++; $display("[TB] FAIL single_run_to_ack: got %0d expected 21", a_at - r_at); end
      n_cmp++;
      if (a_val !== 3'b001) begin n_bad++; $display("[TB] FAIL single_ack: got %b expected 001", a_val); end
      n_cmp++;
      if (e_val !== {2'b00, e.err}) begin n_bad++; $display("[TB] FAIL single_err: got %b expected 000", e_val); end
      n_cmp++;
      if (bad_hold !== 0) begin n_bad++; $display("[TB] FAIL single_xfer_hold: got %0d bad cycles expected 0", bad_hold); end
      n_cmp++;
      if (bram_val !== d_bram[0]) begin n_bad++; $display("[TB] FAIL single_bram: got %h expected %h", bram_val, d_bram[0]); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_start_timeout();
      int r_at, a_at;
      logic [NR-1:0] a_val, e_val;
      exp_t e;
      never_run = 1'b1;
      set_desc(1, 2'd2, 16'h0033, 3'd1, 3'd1, 15'h0123);
      sb.push_back(exp_t'{idx: 1, err: 1'b1, xfer: 16'h0033});
      r_at = -1; a_at = -1; a_val = '0; e_val = '0;
      @(negedge clk);
      bus.req = 3'b010;
      for (int i = 0; i < 100 && a_at < 0; i++) begin
         @(negedge clk);
         if (bus.hsci_master_run && r_at < 0) r_at = cyc;
         if (bus.ack != '0) begin a_at = cyc; a_val = bus.ack; e_val = bus.err; bus.req = '0; end
      end
      e = sb.pop_front();
      n_cmp++;
      if (a_at - r_at !== START_TMO || r_at < 0) begin
         n_bad++;
         $display("[TB] FAIL start_tmo_latency: got %0d expected %0d", a_at - r_at, START_TMO);
      end
      n_cmp++;
      if (a_val !== 3'b010) begin n_bad++; $display("[TB] FAIL start_tmo_ack: got %b expected 010", a_val); end
      n_cmp++;
      if (e_val !== (e.err ? 3'b010 : 3'b000)) begin n_bad++; $display("[TB] FAIL start_tmo_err: got %b expected 010", e_val); end
      never_run = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_core_error();
      bit got;
      int at;
      exp_t e;
      run_len = 5;
      err_on_done = 1'b1;
      set_desc(0, 2'd3, 16'h0044, 3'd4, 3'd2, 15'h0400);
      sb.push_back(exp_t'{idx: 0, err: 1'b1, xfer: 16'h0044});
      sb.push_back(exp_t'{idx: 0, err: 1'b0, xfer: 16'h0044});
      @(negedge clk);
      bus.req = 3'b001;
      wait_ack(100, got, at);
      bus.req = '0;
      e = sb.pop_front();
      n_cmp++;
      if (!got || bus.ack !== 3'b001) begin n_bad++; $display("[TB] FAIL core_err_ack: got %b expected 001", bus.ack); end
      n_cmp++;
      if (bus.err !== (e.err ? 3'b001 : 3'b000)) begin n_bad++; $display("[TB] FAIL core_err_err: got %b expected 001", bus.err); end
      err_on_done = 1'b0;
      repeat (2) @(negedge clk);
      // Second transfer also drops req right after grant; the ack must still arrive.
      bus.req = 3'b001;
      for (int i = 0; i < 20 && bus.grant == '0; i++) @(negedge clk);
      bus.req = '0;
      wait_ack(100, got, at);
      e = sb.pop_front();
      n_cmp++;
      if (!got || bus.ack !== 3'b001) begin n_bad++; $display("[TB] FAIL core_err_next_ack: got %b expected 001", bus.ack); end
      n_cmp++;
      if (bus.err !== (e.err ? 3'b001 : 3'b000)) begin n_bad++; $display("[TB] FAIL core_err_next_err: got %b expected 000", bus.err); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_transfer();
      bit got;
      int at, stray;
      logic [NR-1:0] first_grant;
      exp_t e;
      run_len = 60;
      @(negedge clk);
      bus.req = 3'b100;
      for (int i = 0; i < 30 && !bus.master_running; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      bus.req = '0;
      pulse_reset();
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
      n_cmp++;
      if (bus.grant !== 3'b000) begin n_bad++; $display("[TB] FAIL midrst_grant: got %b expected 000", bus.grant); end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.ack != '0) stray++;
         @(negedge clk);
      end
      n_cmp++;
      if (stray !== 0) begin n_bad++; $display("[TB] FAIL midrst_no_ack: got %0d ack cycles expected 0", stray); end
      run_len = 3;
      sb.push_back(exp_t'{idx: 0, err: 1'b0, xfer: d_xfer[0]});
      bus.req = 3'b111;
      first_grant = '0;
      for (int i = 0; i < 20 && first_grant == '0; i++) begin
         @(negedge clk);
         first_grant = bus.grant;
      end
      n_cmp++;
      if (first_grant !== 3'b001) begin n_bad++; $display("[TB] FAIL midrst_regrant: got %b expected 001", first_grant); end
      wait_ack(100, got, at);
      bus.req = '0;
      e = sb.pop_front();
      n_cmp++;
      if (!got || bus.ack !== 3'b001 || bus.hsci_xfer_num !== e.xfer) begin
         n_bad++;
         $display("[TB] FAIL midrst_ack: got ack %b xfer %h expected ack 001 xfer %h", bus.ack, bus.hsci_xfer_num, e.xfer);
      end
      repeat (3) @(negedge clk);
   endtask

`ifdef HSCI_XFER_TIMEOUT_EN
   task automatic test_xfer_timeout();
      int r_at, a_at;
      logic [NR-1:0] a_val, e_val;
      stuck_run = 1'b1;
      r_at = -1; a_at = -1; a_val = '0; e_val = '0;
      @(negedge clk);
      bus.req = 3'b001;
      for (int i = 0; i < 300 && a_at < 0; i++) begin
         @(negedge clk);
         if (bus.hsci_master_run && r_at < 0) r_at = cyc;
         if (bus.ack != '0) begin a_at = cyc; a_val = bus.ack; e_val = bus.err; bus.req = '0; end
      end
      n_cmp++;
      if (a_at - r_at !== XFER_TMO + 1 || r_at < 0) begin
         n_bad++;
         $display("[TB] FAIL xfer_tmo_latency: got %0d expected %0d", a_at - r_at, XFER_TMO + 1);
      end
      n_cmp++;
      if (a_val !== 3'b001 || e_val !== 3'b001) begin
         n_bad++;
         $display("[TB] FAIL xfer_tmo_ack_err: got ack %b err %b expected 001/001", a_val, e_val);
      end
      stuck_run = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (tmo_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL xfer_tmo_flag_sticky: got %b expected 1", tmo_flag); end
      pulse_reset();
      @(negedge clk);
      n_cmp++;
      if (tmo_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL xfer_tmo_flag_reset: got %b expected 0", tmo_flag); end
   endtask
`endif

   initial begin
      bus.req = '0;
      test_reset();
      test_contention();
      test_single();
      test_start_timeout();
      test_core_error();
      test_reset_mid_transfer();
`ifdef HSCI_XFER_TIMEOUT_EN
      test_xfer_timeout();
`endif
      n_cmp++;
      if (sb.size() !== 0) begin n_bad++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hsci_xfer_arbiter.md
Name: hsci_xfer_arbiter

Overview:
- Shares one HSCI master core (hsci_mcore) between NUM_REQ requesters, e.g. a software-driven register path and hardware sequencers.
- Round-robin arbitration; latches the winner's transfer descriptor and drives the core control inputs (cmd_sel, xfer_num, byte_num, addr_size, bram start address).
- Issues a single-cycle run pulse, tracks master_running / master_done, then returns a per-requester completion or error.
- Sits in the hsci_pclk domain, between the requesters and the core's control/status pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- START_TMO, 16, cycles allowed from run pulse to master_running high.
- XFER_TMO, 65535, cycles allowed in WAIT_DONE; used only when HSCI_XFER_TIMEOUT_EN is defined.

Ports:
- hsci_pclk  in  1  clock.
- hsci_rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until ack.
- req_cmd_sel  in  2*NUM_REQ  command select per requester.
- req_xfer_num  in  16*NUM_REQ  transfer count.
- req_byte_num  in  3*NUM_REQ  bytes per transfer.
- req_addr_size  in  3*NUM_REQ  address size.
- req_bram_addr  in  15*NUM_REQ  BRAM start word address.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  NUM_REQ  valid with ack; 1 = start timeout, transfer timeout, or core error.
- grant  out  NUM_REQ  one-hot; the current owner.
- busy  out  1  high in every state except IDLE.
- hsci_cmd_sel / hsci_xfer_num / hsci_byte_num / hsci_addr_size / hsci_bram_addr  out  2/16/3/3/15  latched descriptor driven to the core.
- hsci_master_run  out  1  single-cycle run pulse.
- master_running  in  1  core status.
- master_done  in  1  core status (level).
- core_err  in  1  OR of parity_err, unk_instr_err, and nonzero error_code (formed externally).

Behaviour:
- Reset:
  - All outputs 0; state IDLE; rr_ptr = 0.
  - Reset mid-transfer aborts immediately; no ack is issued. Requesters re-request after reset.
- FSM: IDLE -> LOAD -> RUN -> WAIT_START -> WAIT_DONE -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick the first requester at or after rr_ptr (modulo NUM_REQ).
  - Set grant and latch its descriptor into the hsci_* outputs at the same edge; go to LOAD.
- LOAD: one cycle so the descriptor settles at the core before run; go to RUN.
- RUN:
  - hsci_master_run = 1 for exactly one cycle.
  - Start counter cleared; go to WAIT_START.
- WAIT_START:
  - master_running = 1 -> WAIT_DONE.
  - Counter reaches START_TMO -> RESP with err flag set.
- WAIT_DONE:
  - master_done = 1 and master_running = 0 -> RESP; err flag = core_err sampled in that cycle.
- RESP:
  - ack[g] = 1 and err[g] = flag for one cycle; grant cleared.
  - rr_ptr = g + 1, wrapping to 0 after NUM_REQ-1.
  - Go to IDLE.
- Throughput: minimum 5 cycles overhead per transfer outside the core's own runtime; back-to-back requests are re-arbitrated in the IDLE cycle.
- Latching and request changes:
  - Descriptor outputs hold their value from latch until the next grant; they are not cleared in IDLE.
  - A granted requester dropping req mid-transfer is ignored; the transfer completes and ack still pulses.
- Simultaneous requests: strict round-robin, so each requester is served within NUM_REQ grants.
- Counters saturate; they never wrap.

Optional Feature:
- Macro: HSCI_XFER_TIMEOUT_EN.
- Defined:
  - 16-bit counter in WAIT_DONE.
  - On reaching XFER_TMO -> RESP with err = 1.
  - Sticky output tmo_flag (1 bit, cleared only by reset) is added to the port list.
- Undefined:
  - WAIT_DONE waits indefinitely.
  - No counter and no tmo_flag port.

Decomposition:
- Package hsci_xfer_arb_pkg:
  - State enum xfer_arb_state_t.
  - Packed descriptor struct xfer_desc_t (cmd_sel, xfer_num, byte_num, addr_size, bram_addr).
  - Width constants.
- Sub-module hsci_rr_arbiter: combinational round-robin pick from req and rr_ptr, returning one-hot grant and index.

Test Plan:
- Single requester: req[0] with xfer_num=4, bram_addr=0x10. Required:
  - Run pulses 2 cycles after grant.
  - Core model raises running for 20 cycles, then done.
  - ack[0] = 1, err = 0, hsci_xfer_num = 4 throughout.
- Contention, NUM_REQ=3: req = 3'b111 held. Required:
  - Grant order 0, 1, 2, 0.
  - Each ack goes to the matching requester.
- Start timeout: core never raises running. Required: ack[1] = 1 with err[1] = 1 exactly START_TMO cycles after the run pulse.
- Core error: core_err = 1 together with done. Required: err[0] = 1 with ack; next request is still served normally.
- Reset in WAIT_DONE: hsci_rst pulsed for 1 cycle. Required:
  - busy = 0, grant = 0, no ack.
  - Next req is granted starting from requester 0.
- Transfer timeout (macro defined, XFER_TMO=100): running stuck high. Required:
  - ack with err = 1 at 100 cycles.
  - tmo_flag = 1 and stays set until reset.
